// File: rtl/mutative_fill_ctrl_if.sv
// Fill-controller bundle: allocation handshake, tag/data array port and memory port.
interface mutative_fill_ctrl_if #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int SET_BITS  = 4,
  parameter int WAYS      = 8
);
  localparam int TAG_BITS     = ADDR_BITS - SET_BITS - 5;
  localparam int WAY_IDX_BITS = $clog2(WAYS);

  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [ADDR_BITS-1:0]    alloc_addr;
  logic [WAY_IDX_BITS-1:0] evict_way;
  logic [WAYS-1:0]         way_valid;
  logic [WAYS-1:0]         way_dirty;
  logic [TAG_BITS-1:0]     victim_tag;
  logic [LINE_BITS-1:0]    victim_data;
  logic [ADDR_BITS-1:0]    arr_addr;
  logic                    arr_rd;
  logic [WAY_IDX_BITS-1:0] arr_way;
  logic [WAYS-1:0]         arr_we;
  logic [TAG_BITS-1:0]     arr_wtag;
  logic [LINE_BITS-1:0]    arr_wdata;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic                    mem_read;
  logic                    mem_write;
  logic [LINE_BITS-1:0]    mem_wdata;
  logic [LINE_BITS-1:0]    mem_rdata;
  logic                    mem_resp;
  logic                    hit;
  logic [WAY_IDX_BITS-1:0] hit_way;
  logic                    alloc_done;

  modport slave (
    input  alloc_valid, alloc_addr, evict_way, way_valid, way_dirty,
           victim_tag, victim_data, mem_rdata, mem_resp,
    output alloc_ready, arr_addr, arr_rd, arr_way, arr_we, arr_wtag, arr_wdata,
           mem_addr, mem_read, mem_write, mem_wdata, hit, hit_way, alloc_done
  );

  modport master (
    output alloc_valid, alloc_addr, evict_way, way_valid, way_dirty,
           victim_tag, victim_data, mem_rdata, mem_resp,
    input  alloc_ready, arr_addr, arr_rd, arr_way, arr_we, arr_wtag, arr_wdata,
           mem_addr, mem_read, mem_write, mem_wdata, hit, hit_way, alloc_done
  );
endinterface

// File: rtl/mutative_fill_ctrl.sv
// Cache miss fill controller: picks a victim way, writes back a dirty victim,
// fetches the missing line and writes it into the array.
module mutative_fill_ctrl #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int SET_BITS  = 4,
  parameter int WAYS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            setup,
  mutative_fill_ctrl_if.slave   bus
);
  localparam int TAG_BITS     = ADDR_BITS - SET_BITS - 5;
  localparam int WAY_IDX_BITS = $clog2(WAYS);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, SELECT, READV, WB, FETCH, FILL, DONE
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [WAY_IDX_BITS-1:0] plru_q;
  logic [WAY_IDX_BITS-1:0] victim_q;
  logic                    rdv_phase;
  logic [TAG_BITS-1:0]     wb_tag_q;
  logic [LINE_BITS-1:0]    wb_data_q;
  logic [LINE_BITS-1:0]    line_q;

  logic [WAY_IDX_BITS-1:0] idx_mask;
  logic [WAY_IDX_BITS-1:0] inv_way;
  logic                    inv_found;
  logic [WAY_IDX_BITS-1:0] sel_way;
  logic                    sel_wb;

  // Reduced associativity keeps only the low index bits of any way number.
  assign idx_mask = WAY_IDX_BITS'((32'd1 << setup) - 32'd1);

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!inv_found && ((WAY_IDX_BITS'(i) & ~idx_mask) == '0) && !bus.way_valid[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_IDX_BITS'(i);
      end
    end
  end

  assign sel_way = inv_found ? inv_way : plru_q;
  assign sel_wb  = bus.way_valid[sel_way] & bus.way_dirty[sel_way];

  assign bus.arr_addr = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      plru_q    <= '0;
      victim_q  <= '0;
      rdv_phase <= 1'b0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      line_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE:   if (bus.alloc_valid) addr_q <= bus.alloc_addr;
        LOOKUP: plru_q <= bus.evict_way & idx_mask;
        SELECT: victim_q <= sel_way;
        READV: begin
          // Phase 0 issues the read, phase 1 sees the victim contents.
          rdv_phase <= ~rdv_phase;
          if (rdv_phase) begin
            wb_tag_q  <= bus.victim_tag;
            wb_data_q <= bus.victim_data;
          end
        end
        FETCH:  if (bus.mem_resp) line_q <= bus.mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx       = state;
    bus.alloc_ready = 1'b0;
    bus.arr_rd     = 1'b0;
    bus.arr_way    = '0;
    bus.arr_we     = '0;
    bus.arr_wtag   = '0;
    bus.arr_wdata  = '0;
    bus.mem_addr   = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_wdata  = '0;
    bus.hit        = 1'b0;
    bus.hit_way    = '0;
    bus.alloc_done = 1'b0;
    case (state)
      IDLE: begin
        bus.alloc_ready = 1'b1;
        if (bus.alloc_valid) state_nx = LOOKUP;
      end
      LOOKUP: begin
        bus.arr_rd  = 1'b1;
        bus.arr_way = bus.evict_way & idx_mask;
        state_nx    = SELECT;
      end
      SELECT: state_nx = sel_wb ? READV : FETCH;
      READV: begin
        if (!rdv_phase) begin
          bus.arr_rd  = 1'b1;
          bus.arr_way = victim_q;
        end else begin
          state_nx = WB;
        end
      end
      WB: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {wb_tag_q, addr_q[SET_BITS+4:5], 5'b0};
        bus.mem_wdata = wb_data_q;
        if (bus.mem_resp) state_nx = FETCH;
      end
      FETCH: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {addr_q[ADDR_BITS-1:5], 5'b0};
        if (bus.mem_resp) state_nx = FILL;
      end
      FILL: begin
        bus.arr_we    = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;
        bus.arr_wtag  = addr_q[ADDR_BITS-1:SET_BITS+5];
        bus.arr_wdata = line_q;
        state_nx      = DONE;
      end
      DONE: begin
        bus.alloc_done = 1'b1;
        bus.hit        = 1'b1;
        bus.hit_way    = victim_q;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mutative_fill_ctrl.sv
// Scoreboard bench for mutative_fill_ctrl: array and memory models plus a
// negedge monitor that pops expected fills as the DUT produces them.
module tb_mutative_fill_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] setup = 2'b00;

  mutative_fill_ctrl_if bus ();
  mutative_fill_ctrl dut (.clk(clk), .rst(rst), .setup(setup), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   we;
    logic [22:0]  wtag;
    logic [255:0] wdata;
    logic [2:0]   way;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [31:0]  fetch_addr;
    int           rd_len;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   resp_delay = 0;

  logic [22:0]  tag_tbl  [8];
  logic [255:0] data_tbl [8];
  logic [2:0]   rd_way_q;

  // Array model: victim contents follow the way read on the previous cycle.
  always @(posedge clk) if (bus.arr_rd) rd_way_q <= bus.arr_way;
  assign bus.victim_tag  = tag_tbl[rd_way_q];
  assign bus.victim_data = data_tbl[rd_way_q];
  assign bus.mem_rdata   = {8{bus.mem_addr ^ 32'h5A5A_0F0F}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] addr, input logic [2:0] way,
                                  input logic wb, input int dly);
    exp_t e;
    e.way        = way;
    e.wb         = wb;
    e.we         = 8'd1 << way;
    e.wtag       = addr[31:9];
    e.wb_addr    = {tag_tbl[way], addr[8:5], 5'b0};
    e.wb_data    = data_tbl[way];
    e.fetch_addr = {addr[31:5], 5'b0};
    e.wdata      = {8{e.fetch_addr ^ 32'h5A5A_0F0F}};
    e.rd_len     = dly + 1;
    return e;
  endfunction

  // Memory model: responds resp_delay cycles after each new request.
  initial begin
    int   cnt;
    logic pw, pr;
    cnt = 0; pw = 1'b0; pr = 1'b0;
    bus.mem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.mem_write && !pw) || (bus.mem_read && !pr)) cnt = 0;
      else if (bus.mem_read || bus.mem_write) cnt++;
      pw = bus.mem_write;
      pr = bus.mem_read;
      bus.mem_resp = (bus.mem_read || bus.mem_write) && (cnt >= resp_delay);
    end
  end

  // Monitor.
  initial begin
    logic        pr, pw, stable, rdy_low;
    int          rdlen;
    logic [31:0] a0;
    pr = 1'b0; pw = 1'b0; stable = 1'b1; rdy_low = 1'b1; rdlen = 0; a0 = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pr = 1'b0; pw = 1'b0;
        continue;
      end
      if (bus.mem_read || bus.mem_write)
        chk("rd_wr_excl", bus.mem_read & bus.mem_write, 0);
      if (bus.mem_write && !pw) begin
        chk("wb_sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          chk("wb_expected", bus.mem_write, sbq[0].wb);
          chk("wb_addr", bus.mem_addr, sbq[0].wb_addr);
          chk("wb_data", bus.mem_wdata, sbq[0].wb_data);
        end
      end
      if (bus.mem_read && !pr) begin
        a0 = bus.mem_addr; rdlen = 0; stable = 1'b1; rdy_low = 1'b1;
        if (sbq.size() != 0) chk("fetch_addr", bus.mem_addr, sbq[0].fetch_addr);
      end
      if (bus.mem_read) begin
        rdlen++;
        if (bus.mem_addr !== a0) stable = 1'b0;
        if (bus.alloc_ready) rdy_low = 1'b0;
      end
      if (!bus.mem_read && pr && sbq.size() != 0) begin
        chk("rd_len", rdlen, sbq[0].rd_len);
        chk("rd_addr_stable", stable, 1);
        chk("rd_ready_low", rdy_low, 1);
      end
      if (bus.arr_we != '0) begin
        chk("fill_sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          cur = sbq.pop_front();
          chk("arr_we", bus.arr_we, cur.we);
          chk("arr_wtag", bus.arr_wtag, cur.wtag);
          chk("arr_wdata", bus.arr_wdata, cur.wdata);
        end
      end
      if (bus.alloc_done) begin
        chk("hit", bus.hit, 1);
        chk("hit_way", bus.hit_way, cur.way);
      end
      pr = bus.mem_read;
      pw = bus.mem_write;
    end
  end

  task automatic cfg(input logic [1:0] su, input logic [7:0] v, input logic [7:0] d,
                     input logic [2:0] ev, input int dly);
    setup = su; bus.way_valid = v; bus.way_dirty = d; bus.evict_way = ev; resp_delay = dly;
  endtask

  task automatic start_alloc(input logic [31:0] addr, input logic [2:0] xway,
                             input logic xwb, input int dly);
    int n;
    sbq.push_back(mk_exp(addr, xway, xwb, dly));
    @(negedge clk);
    n = 0;
    while (!bus.alloc_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", bus.alloc_ready, 1);
    bus.alloc_addr = addr; bus.alloc_valid = 1'b1;
    @(negedge clk);
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wait_done(input int xlat);
    int n;
    n = 1;
    while (!bus.alloc_done && n < 200) begin @(negedge clk); n++; end
    chk("done_seen", bus.alloc_done, 1);
    if (xlat > 0) chk("latency", n, xlat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      tag_tbl[i]  = 23'h100 + 23'(i);
      data_tbl[i] = {8{32'hD000_0000 + 32'(i)}};
    end
    tag_tbl[5] = 23'h1;
    bus.alloc_valid = 1'b0; bus.alloc_addr = '0;
    cfg(2'b00, 8'h00, 8'h00, 3'd0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.alloc_ready, 1);
    chk("rst_arr_rd", bus.arr_rd, 0);
    chk("rst_arr_we", bus.arr_we, 0);
    chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
    chk("rst_hit_done", {bus.hit, bus.alloc_done}, 0);
    chk("rst_arr_addr", bus.arr_addr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b1;

    // 4 ways, way 2 the only invalid one; clean path latency.
    cfg(2'b10, 8'b0000_1011, 8'h00, 3'd1, 0);
    start_alloc(32'h1234_5660, 3'd2, 1'b0, 0); wait_done(5);
    // 8 ways all valid, PLRU way 5 dirty with tag 0x1.
    cfg(2'b11, 8'hFF, 8'h20, 3'd5, 0);
    start_alloc(32'hCAFE_01A0, 3'd5, 1'b1, 0); wait_done(0);
    // Direct-mapped: PLRU way 6 collapses to way 0.
    cfg(2'b00, 8'hFF, 8'h00, 3'd6, 0);
    start_alloc(32'h0000_8020, 3'd0, 1'b0, 0); wait_done(5);
    // 2 ways: invalid ways outside the active range are ignored.
    cfg(2'b01, 8'hF3, 8'h00, 3'd7, 0);
    start_alloc(32'h7654_3200, 3'd1, 1'b0, 0); wait_done(5);
    cfg(2'b01, 8'b0000_0001, 8'hFF, 3'd0, 0);
    start_alloc(32'h1111_11E0, 3'd1, 1'b0, 0); wait_done(5);
    // Invalid-but-dirty way must not be written back.
    cfg(2'b11, 8'hFE, 8'h01, 3'd4, 0);
    start_alloc(32'hABCD_0040, 3'd0, 1'b0, 0); wait_done(5);
    // Slow memory on fetch.
    cfg(2'b11, 8'hFF, 8'h00, 3'd3, 10);
    start_alloc(32'h2468_ACE0, 3'd3, 1'b0, 10); wait_done(15);

    // Reset in the middle of a write-back.
    cfg(2'b11, 8'hFF, 8'h20, 3'd5, 20);
    start_alloc(32'h1357_9BC0, 3'd5, 1'b1, 20);
    n = 0;
    while (!bus.mem_write && n < 50) begin @(negedge clk); n++; end
    chk("wb_reached", bus.mem_write, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_mem_write", bus.mem_write, 0);
    chk("mid_rst_ready", bus.alloc_ready, 1);
    chk("mid_rst_arr_addr", bus.arr_addr, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    cfg(2'b10, 8'b0000_1011, 8'h00, 3'd0, 0);
    start_alloc(32'h0BAD_F000, 3'd2, 1'b0, 0); wait_done(5);

    // Back-to-back requests with alloc_valid held high.
    cfg(2'b10, 8'b0000_1011, 8'h00, 3'd0, 0);
    sbq.push_back(mk_exp(32'h5555_5540, 3'd2, 1'b0, 0));
    sbq.push_back(mk_exp(32'h5555_5540, 3'd2, 1'b0, 0));
    @(negedge clk);
    bus.alloc_addr = 32'h5555_5540; bus.alloc_valid = 1'b1;
    @(negedge clk);
    wait_done(5);
    chk("b2b_ready_in_done", bus.alloc_ready, 0);
    @(negedge clk);
    chk("b2b_ready_idle", bus.alloc_ready, 1);
    @(negedge clk);
    chk("b2b_second_accepted", bus.alloc_ready, 0);
    bus.alloc_valid = 1'b0;
    wait_done(5);

    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mutative_fill_ctrl.md
MUTATIVE_FILL_CTRL -- requirements
Module: mutative_fill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32: byte address width.
REQ-002 SHALL have parameter LINE_BITS, default 256: cache line width; offset field is 5 bits.
REQ-003 SHALL have parameter SET_BITS, default 4: set index width at addr[8:5]; tag = addr[31:9], TAG_BITS = ADDR_BITS-SET_BITS-5.
REQ-004 SHALL have parameter WAYS, default 8, with WAY_IDX_BITS = 3.
REQ-005 clk  in  1  single clock; all state on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 setup  in  2  associativity: 00=1 way, 01=2, 10=4, 11=8 ways.
REQ-008 alloc_valid  in  1  miss needs a line; alloc_addr stable while alloc_valid.
REQ-009 alloc_addr  in  ADDR_BITS  miss address.
REQ-010 alloc_ready  out  1  high only in IDLE.
REQ-011 evict_way  in  WAY_IDX_BITS  PLRU victim for the set on arr_addr.
REQ-012 way_valid, way_dirty  in  WAYS each  per-way status of the addressed set, valid the cycle after arr_rd.
REQ-013 victim_tag  in  TAG_BITS; victim_data  in  LINE_BITS  content of way arr_way, valid the cycle after arr_rd.
REQ-014 arr_addr  out  ADDR_BITS  latched miss address; arr_rd  out  1; arr_way  out  WAY_IDX_BITS.
REQ-015 arr_we  out  WAYS  one-hot fill write enable; arr_wtag  out  TAG_BITS; arr_wdata  out  LINE_BITS.
REQ-016 mem_addr  out  ADDR_BITS; mem_read, mem_write  out  1; mem_wdata  out  LINE_BITS; mem_rdata  in  LINE_BITS; mem_resp  in  1.
REQ-017 hit  out  1; hit_way  out  WAY_IDX_BITS  PLRU touch of the filled way.
REQ-018 alloc_done  out  1  one-cycle completion pulse.

Function
REQ-019 FSM states IDLE, LOOKUP, SELECT, READV, WB, FETCH, FILL, DONE.
REQ-020 IDLE: alloc_valid=1 -> latch alloc_addr into arr_addr, go LOOKUP; else stay.
REQ-021 LOOKUP: arr_rd=1 for one cycle, arr_way = evict_way masked to active width; go SELECT.
REQ-022 SELECT: victim = lowest-index invalid way among active ways, else masked evict_way; latched.
REQ-023 Active ways: indices 0..N-1 for N per setup; upper index bits forced 0 (setup 00 -> way 0 always).
REQ-024 SELECT: latched victim valid and dirty -> READV; else -> FETCH.
REQ-025 READV: arr_rd=1, arr_way=victim, one cycle; next cycle captures victim_tag/victim_data, go WB.
REQ-026 WB: mem_write=1, mem_addr={victim_tag, set, 5'b0}, mem_wdata=captured data, held until mem_resp=1, then FETCH.
REQ-027 FETCH: mem_read=1, mem_addr={arr_addr[31:5], 5'b0}, held until mem_resp=1; capture mem_rdata, go FILL.
REQ-028 FILL: arr_we = 1<<victim, arr_wtag = arr_addr[31:9], arr_wdata = captured line, one cycle; go DONE.
REQ-029 DONE: alloc_done=1, hit=1, hit_way=victim, one cycle; return IDLE.
REQ-030 mem_read and mem_write never both high; neither high outside WB/FETCH.
REQ-031 mem_resp outside WB/FETCH SHALL be ignored.
REQ-032 Minimum latency (clean victim, mem_resp same cycle as request) alloc accept to alloc_done: 5 cycles.
REQ-033 setup change while busy is unsupported; setup sampled only in LOOKUP/SELECT.

Reset
REQ-034 rst low asynchronously forces IDLE, clears latched address/victim/data.
REQ-035 During reset: alloc_ready=1 on release; arr_rd, arr_we, mem_read, mem_write, hit, alloc_done = 0; all data/address outputs 0.
REQ-036 Reset mid-WB/FETCH abandons transfer; no arr_we or hit follows.

Verification
REQ-037 setup=10, way_valid=4'b1011 -> victim way 2, no WB, arr_we=8'b00000100, hit_way=2.
REQ-038 setup=11, all valid, evict_way=5, way 5 dirty tag 0x1 -> mem_write at {0x1, set, 5'b0}, then mem_read, arr_we=8'b00100000.
REQ-039 setup=00, evict_way=6 -> victim way 0, hit_way=0.
REQ-040 mem_resp delayed 10 cycles in FETCH -> mem_read held 11 cycles, mem_addr stable, alloc_ready=0 throughout.
REQ-041 rst pulsed low during WB -> outputs cleared immediately, IDLE, no arr_we; next alloc completes normally.
REQ-042 back-to-back alloc_valid -> second accepted only after alloc_done, one cycle in IDLE.
